// File: rtl/thread_msg_ctlr.sv
// Queues ALU FORK/STOP requests, issues them one at a time on the shared message bus, and returns ok/err.
// Latency: enqueue -> bus_req 1 cycle -> issue pulse 1 cycle after grant -> response the cycle after the matching DONE.
// Backpressure: req_ready drops while the queue is full; the queue head stays until the ALU accepts its response.
module thread_msg_ctlr #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MSG_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int HDR_SPACE   = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int MAX_RETRY   = 3,
  parameter logic [MSG_W-1:0] MSG_FORK      = 8'h01,
  parameter logic [MSG_W-1:0] MSG_STOP      = 8'h02,
  parameter logic [MSG_W-1:0] MSG_FORK_DONE = 8'h81,
  parameter logic [MSG_W-1:0] MSG_STOP_DONE = 8'h82
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_req_valid,
  output logic                          o_req_ready,
  input  logic                          i_req_op,
  input  logic [ADDR_W-1:0]             i_req_src0,
  input  logic [DATA_W-1:0]             i_req_src1,
  input  logic [ADDR_W-1:0]             i_base_addr,
  input  logic [ADDR_W-1:0]             i_base_addr_data,
  input  logic                          i_disp_online,
  output logic                          o_bus_req,
  input  logic                          i_bus_gnt,
  output logic [MSG_W-1:0]              o_msg_out,
  output logic                          o_msg_out_en,
  output logic [ADDR_W-1:0]             o_addr_out,
  output logic [DATA_W-1:0]             o_data_out,
  input  logic [MSG_W-1:0]              i_msg_in,
  output logic                          o_rsp_valid,
  input  logic                          i_rsp_ready,
  output logic                          o_rsp_op,
  output logic                          o_rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   o_pending
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [2:0] {S_IDLE, S_ARB, S_SEND, S_WAIT, S_RESP} state_t;

  // Request queue storage
  logic              r_fifo_op   [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              r_req_ready;

  // Controller state and registered outputs
  state_t            r_state;
  logic [TW-1:0]     r_timer;
  logic [RW-1:0]     r_retry;
  logic              r_bus_req;
  logic              r_msg_out_en;
  logic [MSG_W-1:0]  r_msg_out;
  logic [ADDR_W-1:0] r_addr_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_rsp_valid;
  logic              r_rsp_op;
  logic              r_rsp_err;

  logic              w_push;
  logic              w_pop;
  logic [CW-1:0]     w_count_nxt;
  logic [ADDR_W-1:0] w_hdr_addr;
  logic [DATA_W-1:0] w_hdr_data;
  logic [ADDR_W-1:0] w_enq_addr;
  logic [DATA_W-1:0] w_enq_data;
  logic              w_head_op;
  logic [MSG_W-1:0]  w_done_code;

  assign w_push      = i_req_valid & r_req_ready;
  assign w_pop       = (r_state == S_RESP) & i_rsp_ready;
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // STOP requests point past the thread header, so the header size is taken off both addresses
  assign w_hdr_addr = i_req_op ? ADDR_W'(HDR_SPACE) : '0;
  assign w_hdr_data = i_req_op ? DATA_W'(HDR_SPACE) : '0;
  assign w_enq_addr = i_req_src0 + i_base_addr - w_hdr_addr;
  // A zero data offset means "no data segment" and must stay zero rather than become a based address
  assign w_enq_data = (i_req_src1 == '0) ? '0
                    : (i_req_src1 + DATA_W'(i_base_addr_data) - w_hdr_data);

  assign w_head_op   = r_fifo_op[r_rptr];
  assign w_done_code = w_head_op ? MSG_STOP_DONE : MSG_FORK_DONE;

  // Capture the resolved request into the tail slot
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_op[r_wptr]   <= i_req_op;
      r_fifo_addr[r_wptr] <= w_enq_addr;
      r_fifo_data[r_wptr] <= w_enq_data;
    end
  end

  // Queue pointers, occupancy and a registered ready derived from next-cycle occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_req_ready <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count     <= w_count_nxt;
      r_req_ready <= (w_count_nxt != CW'(FIFO_DEPTH));
    end
  end

  // Issue the head request: arbitrate, pulse it onto the bus, wait for DONE with retries, respond
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_retry      <= '0;
      r_bus_req    <= 1'b0;
      r_msg_out_en <= 1'b0;
      r_msg_out    <= '0;
      r_addr_out   <= '0;
      r_data_out   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_op     <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((r_count != '0) && i_disp_online) begin
            r_state   <= S_ARB;
            r_bus_req <= 1'b1;
          end
        end
        S_ARB: begin
          // Losing the dispatcher before the grant backs out without spending a retry
          if (!i_disp_online) begin
            r_state   <= S_IDLE;
            r_bus_req <= 1'b0;
          end else if (i_bus_gnt) begin
            r_state      <= S_SEND;
            r_msg_out_en <= 1'b1;
            r_msg_out    <= w_head_op ? MSG_STOP : MSG_FORK;
            r_addr_out   <= r_fifo_addr[r_rptr];
            r_data_out   <= r_fifo_data[r_rptr];
          end
        end
        S_SEND: begin
          r_state      <= S_WAIT;
          r_timer      <= '0;
          r_bus_req    <= 1'b0;
          r_msg_out_en <= 1'b0;
          r_msg_out    <= '0;
          r_addr_out   <= '0;
          r_data_out   <= '0;
        end
        S_WAIT: begin
          // DONE is checked first so it wins over a coincident timeout
          if (i_msg_in == w_done_code) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= w_head_op;
            r_rsp_err   <= 1'b0;
          end else if (!i_disp_online) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_op    <= w_head_op;
            r_rsp_err   <= 1'b1;
          end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
            if (r_retry < RW'(MAX_RETRY)) begin
              r_retry   <= r_retry + RW'(1);
              r_state   <= S_ARB;
              r_bus_req <= 1'b1;
            end else begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_op    <= w_head_op;
              r_rsp_err   <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= S_IDLE;
            r_retry     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_op    <= 1'b0;
            r_rsp_err   <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_pending    = r_count;
  assign o_bus_req    = r_bus_req;
  assign o_msg_out_en = r_msg_out_en;
  assign o_msg_out    = r_msg_out;
  assign o_addr_out   = r_addr_out;
  assign o_data_out   = r_data_out;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_op     = r_rsp_op;
  assign o_rsp_err    = r_rsp_err;

endmodule
